// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receive definitions: FSM encoding and parity-type constants.
package uart_rx_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    DONE   = ST_DONE
  } rx_state_t;

  function automatic logic par_bit(
    input logic [7:0] d,
    input logic       typ
  );
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge/bit counters and 3-sample mid-bit majority vote.
module uart_rx_sampler #(
  parameter int PRESC_W = 6,
  parameter int BW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               rx,
  output logic               sampled_bit,
  output logic               sample_valid,
  output logic               bit_end,
  output logic [BW-1:0]      bit_cnt
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;
  logic [2:0]         smp;

  assign half = prescale >> 1;
  assign last = prescale - ONE;

  // start marks the detect cycle as edge 0, so counting resumes at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      smp      <= 3'b111;
    end else if (start) begin
      edge_cnt <= ONE;
      bit_cnt  <= '0;
    end else if (run) begin
      if (edge_cnt == last) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else begin
        edge_cnt <= edge_cnt + ONE;
      end
      if (edge_cnt == half - ONE) smp[0] <= rx;
      if (edge_cnt == half)       smp[1] <= rx;
      if (edge_cnt == half + ONE) smp[2] <= rx;
    end else begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end
  end

  assign sampled_bit  = (smp[0] & smp[1]) |
                        (smp[0] & smp[2]) |
                        (smp[1] & smp[2]);
  assign sample_valid = run && (edge_cnt == half + TWO);
  assign bit_end      = run && (edge_cnt == last);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: FSM, deserializer, parity/stop checks, output regs.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = $clog2(DATA_WIDTH + 3);

  rx_state_t state, nxt;

  logic [PRESC_W-1:0]    presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  wait_hi;
  logic                  start;
  logic                  run;
  logic                  sbit;
  logic                  svalid;
  logic                  bend;
  logic [BW-1:0]         bit_cnt;
  logic                  par_exp;

  assign run = (state == START) || (state == DATA) ||
               (state == PARITY) || (state == STOP);

  assign par_exp = (par_typ_q == PAR_ODD) ? ~^shreg : ^shreg;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W),
    .BW      (BW)
  ) u_sampler (
    .clk          (CLK),
    .rst_n        (RST),
    .start        (start),
    .run          (run),
    .prescale     (presc_q),
    .rx           (RX_IN),
    .sampled_bit  (sbit),
    .sample_valid (svalid),
    .bit_end      (bend),
    .bit_cnt      (bit_cnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  // a line stuck low after a stop error must go high before re-arming
  always_comb begin
    nxt   = state;
    start = 1'b0;
    unique case (state)
      IDLE: begin
        if (!RX_IN && !wait_hi) begin
          nxt   = START;
          start = 1'b1;
        end
      end
      START: begin
        if (bend) nxt = sbit ? IDLE : DATA;
      end
      DATA: begin
        if (bend && bit_cnt == BW'(DATA_WIDTH))
          nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bend) nxt = STOP;
      end
      STOP: begin
        if (svalid) nxt = DONE;
      end
      DONE: begin
        if (!RX_IN && !STP_ERR) begin
          nxt   = START;
          start = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shreg      <= '0;
      wait_hi    <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (RX_IN)
        wait_hi <= 1'b0;
      else if (state == DONE && STP_ERR)
        wait_hi <= 1'b1;
      if (start) begin
        presc_q   <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        PAR_ERR   <= 1'b0;
        STP_ERR   <= 1'b0;
      end
      if (state == DATA && svalid)
        shreg <= {sbit, shreg[DATA_WIDTH-1:1]};
      if (state == PARITY && svalid)
        PAR_ERR <= (sbit != par_exp);
      if (state == STOP && svalid)
        STP_ERR <= ~sbit;
      if (state == DONE && !PAR_ERR && !STP_ERR) begin
        P_DATA     <= shreg;
        DATA_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with hand-computed frames.
module tb_uart_rx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int base;
  logic [7:0] hist[$];

  uart_rx_frame #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (DATA_VALID) begin
      dv_cnt++;
      hist.push_back(P_DATA);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int p, input bit gl);
    for (int j = 0; j < p; j++) begin
      @(negedge CLK);
      RX_IN = (gl && j == p / 2) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p,
                            input bit pen, input logic pb,
                            input logic sb, input int gl_bit);
    send_bit(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, gl_bit == i);
    if (pen) send_bit(pb, p, 1'b0);
    send_bit(sb, p, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_dv", DATA_VALID, 1'b0);
    check("rst_par", PAR_ERR, 1'b0);
    check("rst_stp", STP_ERR, 1'b0);
    RST = 1'b1;
    idle(4);

    // P=8, no parity, 0xA5
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    base = dv_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("a5_dv", dv_cnt - base, 1);
    check("a5_data", P_DATA, 8'hA5);
    check("a5_par", PAR_ERR, 1'b0);
    check("a5_stp", STP_ERR, 1'b0);

    // P=16, even parity; ^0x3C = 0
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    base = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    idle(32);
    check("3c_dv", dv_cnt - base, 1);
    check("3c_data", P_DATA, 8'h3C);
    check("3c_par", PAR_ERR, 1'b0);

    base = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    idle(32);
    check("3cbad_par", PAR_ERR, 1'b1);
    check("3cbad_dv", dv_cnt - base, 0);
    check("3cbad_data", P_DATA, 8'h3C);

    // P=32, odd parity; ~^0x81 = 1; stop bit 0
    PRESCALE = 6'd32; PAR_TYP = 1'b1;
    base = dv_cnt;
    send_frame(8'h81, 32, 1'b1, 1'b1, 1'b0, -1);
    idle(64);
    check("81_stp", STP_ERR, 1'b1);
    check("81_par", PAR_ERR, 1'b0);
    check("81_dv", dv_cnt - base, 0);
    base = dv_cnt;
    send_frame(8'h81, 32, 1'b1, 1'b1, 1'b1, -1);
    idle(64);
    check("81ok_stp", STP_ERR, 1'b0);
    check("81ok_dv", dv_cnt - base, 1);
    check("81ok_data", P_DATA, 8'h81);

    // start glitch: low for 3 cycles only
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    base = dv_cnt;
    send_bit(1'b0, 3, 1'b0);
    idle(24);
    check("gl_dv", dv_cnt - base, 0);
    check("gl_par", PAR_ERR, 1'b0);
    check("gl_stp", STP_ERR, 1'b0);
    check("gl_data", P_DATA, 8'h81);

    // back-to-back 0x55, 0xAA
    base = dv_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("b2b_dv", dv_cnt - base, 2);
    if (hist.size() >= 2) begin
      check("b2b_d0", hist[hist.size()-2], 8'h55);
      check("b2b_d1", hist[hist.size()-1], 8'hAA);
    end else begin
      check("b2b_hist", hist.size(), 2);
    end

    // mid-bit glitch on data bit 2 of 0x5A
    base = dv_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 2);
    idle(16);
    check("mv_dv", dv_cnt - base, 1);
    check("mv_data", P_DATA, 8'h5A);

    // reset mid-DATA
    send_bit(1'b0, 8, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    send_bit(1'b1, 4, 1'b0);
    RST = 1'b0;
    #1;
    check("mrst_data", P_DATA, 8'h00);
    check("mrst_dv", DATA_VALID, 1'b0);
    check("mrst_par", PAR_ERR, 1'b0);
    check("mrst_stp", STP_ERR, 1'b0);
    base = dv_cnt;
    idle(3);
    RST = 1'b1;
    idle(8);
    check("mrst_nodv", dv_cnt - base, 0);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("0f_dv", dv_cnt - base, 1);
    check("0f_data", P_DATA, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
